// File: rtl/key_schedule_192_ctrl.sv
// rtl/key_schedule_192_ctrl.sv - iterative AES-192 key expansion with registered round-key read port
module key_schedule_192_ctrl #(
    parameter int NUM_ITER   = 8,
    parameter int NUM_ROUNDS = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [191:0] key_in,
    output logic         busy,
    output logic         key_valid,
    input  logic         rd_en,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         rd_valid,
    output logic         rd_err
);

    localparam logic [2:0] LAST_ITER  = 3'(NUM_ITER - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t         state, state_next;
    logic [2:0]     iter;
    logic [191:0]   cur;
    logic [191:0]   step_out;
    logic           load;

    // blocks[i] holds w[6i..6i+5]; tail holds w48..w51 from the truncated last iteration
    logic [191:0]   blocks [0:7];
    logic [127:0]   tail;
    logic [31:0]    w [0:51];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254, zero maps to zero) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [191:0] key_step(input logic [191:0] k, input logic [2:0] rc);
        logic [31:0]  t;
        logic [191:0] n;
        t = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])}
            ^ {8'h01 << rc, 24'h000000};
        n[191:160] = k[191:160] ^ t;
        n[159:128] = k[159:128] ^ n[191:160];
        n[127:96]  = k[127:96]  ^ n[159:128];
        n[95:64]   = k[95:64]   ^ n[127:96];
        n[63:32]   = k[63:32]   ^ n[95:64];
        n[31:0]    = k[31:0]    ^ n[63:32];
        return n;
    endfunction

    assign step_out = key_step(cur, iter);
    assign load     = start && (state != EXPAND);

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        key_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = EXPAND;
            end
            EXPAND: begin
                busy = 1'b1;
                if (iter == LAST_ITER) state_next = DONE;
            end
            DONE: begin
                key_valid = 1'b1;
                if (start) state_next = EXPAND;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            iter  <= 3'd0;
            cur   <= 192'd0;
        end else begin
            state <= state_next;
            if (load) begin
                iter <= 3'd0;
                cur  <= key_in;
            end else if (state == EXPAND) begin
                iter <= iter + 3'd1;
                cur  <= step_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            blocks[0] <= key_in;
        end else if (state == EXPAND) begin
            if (iter == LAST_ITER) tail <= step_out[191:64];
            else                   blocks[3'(iter + 3'd1)] <= step_out;
        end
    end

    always_comb begin
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 6; k++) begin
                w[6*b + k] = blocks[b][191 - 32*k -: 32];
            end
        end
        for (int k = 0; k < 4; k++) begin
            w[48 + k] = tail[127 - 32*k -: 32];
        end
    end

    logic       rd_ok;
    logic [3:0] rd_sel;
    logic [5:0] rd_base;

    // key_valid here is the pre-start value, so a read alongside a restart sees the old schedule
    assign rd_ok   = key_valid && (rd_idx <= LAST_ROUND);
    assign rd_sel  = (rd_idx <= LAST_ROUND) ? rd_idx : 4'd0;
    assign rd_base = {rd_sel, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_key   <= 128'd0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_err   <= rd_en && !rd_ok;
            if (rd_en) begin
                rd_key <= rd_ok ? {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]}
                                : 128'd0;
            end
        end
    end

endmodule

// File: tb/tb_key_schedule_192_ctrl.sv
// tb/tb_key_schedule_192_ctrl.sv - directed bench for key_schedule_192_ctrl
module tb_key_schedule_192_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [191:0] key_in;
    logic         busy;
    logic         key_valid;
    logic         rd_en;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         rd_valid;
    logic         rd_err;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [191:0] KEY_A  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] GOLD_0 = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] GOLD_1 = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] GOLD_C = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] ZERO_1 = 128'h00000000000000006263636362636363;

    logic [7:0]  sb [0:255];
    logic [31:0] mw [0:51];

    always #5 clk = ~clk;

    key_schedule_192_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .key_valid (key_valid),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_key    (rd_key),
        .rd_valid  (rd_valid),
        .rd_err    (rd_err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // S-box from the log/antilog walk over generator 3 and its inverse
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;
    endtask

    task automatic model(input logic [191:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 6; i++) mw[i] = k[191 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 6; i < 52; i++) begin
            t = mw[i-1];
            if (i % 6 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            mw[i] = mw[i-6] ^ t;
        end
    endtask

    function automatic logic [127:0] mkey(input int r);
        return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endfunction

    task automatic wait_done(input string tag, input int from);
        for (int c = from; c <= 9; c++) begin
            if (c < 9) check($sformatf("%s_busy_c%0d", tag, c), 128'({busy, key_valid}), 128'(2'b10));
            else       check($sformatf("%s_done", tag), 128'({busy, key_valid}), 128'(2'b01));
            if (c < 9) @(negedge clk);
        end
    endtask

    task automatic read1(input string tag, input logic [3:0] idx, input logic [127:0] exp_key,
                         input logic exp_err);
        rd_en  = 1'b1;
        rd_idx = idx;
        @(negedge clk);
        rd_en = 1'b0;
        check({tag, "_vld"}, 128'({rd_valid, rd_err}), 128'({1'b1, exp_err}));
        check({tag, "_key"}, rd_key, exp_key);
        @(negedge clk);
        check({tag, "_idle"}, 128'({rd_valid, rd_err}), 128'(2'b00));
    endtask

    task automatic burst(input string tag);
        rd_en  = 1'b1;
        rd_idx = 4'd0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            check($sformatf("%s_vld%0d", tag, i), 128'({rd_valid, rd_err}), 128'(2'b10));
            check($sformatf("%s_key%0d", tag, i), rd_key, mkey(i));
            rd_idx = 4'(i + 1);
            if (i == 12) rd_en = 1'b0;
        end
        @(negedge clk);
        check({tag, "_end"}, 128'({rd_valid, rd_err}), 128'(2'b00));
        check({tag, "_hold"}, rd_key, mkey(12));
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        rd_en  = 1'b0;
        rd_idx = 4'd0;
        build_sbox();
        model(KEY_A);
        repeat (2) @(negedge clk);
        check("rst_flags", 128'({busy, key_valid, rd_valid, rd_err}), 128'(4'b0000));
        check("rst_key", rd_key, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        read1("pre_key", 4'd0, 128'd0, 1'b1);

        // FIPS-197 A.2 expansion, with a read issued mid-expansion
        start  = 1'b1;
        key_in = KEY_A;
        @(negedge clk);
        start = 1'b0;
        check("t1_busy_c1", 128'({busy, key_valid}), 128'(2'b10));
        @(negedge clk);
        rd_en  = 1'b1;
        rd_idx = 4'd0;
        @(negedge clk);
        rd_en = 1'b0;
        check("exp_rd_vld", 128'({rd_valid, rd_err}), 128'(2'b11));
        check("exp_rd_key", rd_key, 128'd0);
        @(negedge clk);
        check("exp_rd_idle", 128'({rd_valid, rd_err}), 128'(2'b00));
        wait_done("t1", 4);
        read1("r0", 4'd0, GOLD_0, 1'b0);
        read1("r1", 4'd1, GOLD_1, 1'b0);
        read1("r12", 4'd12, GOLD_C, 1'b0);
        burst("bA");
        read1("idx13", 4'd13, 128'd0, 1'b1);
        read1("idx15", 4'd15, 128'd0, 1'b1);

        // restart from DONE; a second start mid-expansion must be ignored
        start  = 1'b1;
        key_in = KEY_A;
        @(negedge clk);
        start = 1'b0;
        check("t5_kv_drop", 128'({busy, key_valid}), 128'(2'b10));
        @(negedge clk);
        start  = 1'b1;
        key_in = 192'd0;
        @(negedge clk);
        start  = 1'b0;
        key_in = KEY_A;
        wait_done("t5", 3);
        read1("t5_r12", 4'd12, GOLD_C, 1'b0);
        burst("bB");

        // zero key from DONE with a read in the start cycle (served from the old key)
        start  = 1'b1;
        key_in = 192'd0;
        rd_en  = 1'b1;
        rd_idx = 4'd12;
        @(negedge clk);
        start = 1'b0;
        rd_en = 1'b0;
        check("st_rd_vld", 128'({rd_valid, rd_err}), 128'(2'b10));
        check("st_rd_key", rd_key, GOLD_C);
        wait_done("tz", 1);
        read1("z_r1", 4'd1, ZERO_1, 1'b0);
        model(192'd0);
        burst("bZ");

        // asynchronous reset in the middle of an expansion
        model(KEY_A);
        start  = 1'b1;
        key_in = KEY_A;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rd_en  = 1'b1;
        rd_idx = 4'd0;
        @(negedge clk);
        rd_en = 1'b0;
        check("t6_pre", 128'({busy, rd_valid, rd_err}), 128'(3'b111));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async", 128'({busy, key_valid, rd_valid, rd_err}), 128'(4'b0000));
        check("t6_key", rd_key, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read1("t6_idle_rd", 4'd0, 128'd0, 1'b1);
        start  = 1'b1;
        key_in = KEY_A;
        @(negedge clk);
        start = 1'b0;
        wait_done("t6", 1);
        burst("bC");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
